audio_dac_tx: RTL and testbench

AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

---
 rtl/audio_dac_tx_pkg.sv | 16 +
 rtl/audio_dac_tx_if.sv | 28 ++
 rtl/audio_sample_fifo.sv | 60 ++++++
 rtl/audio_dac_tx.sv | 129 ++++++++++++
 tb/tb_audio_dac_tx.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_dac_tx_pkg.sv
// Shared types and constants for the audio DAC transmitter.
// Frame layout: 4-bit command prefix followed by a 12-bit sample.
package audio_dac_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } dac_state_e;

  localparam int FRAME_BITS = 16;
  localparam int SAMPLE_W = 12;
  localparam logic [3:0] CTRL_WORD_DEF = 4'b0011;

endpackage

// File: rtl/audio_dac_tx_if.sv
// Sample input strobe and DAC serial lines.
// master = sample producer, slave = transmitter.
interface audio_dac_tx_if;
  import audio_dac_tx_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_in;
  logic                dac_cs_n;
  logic                dac_sclk;
  logic                dac_din;

  modport master (
    output sample_valid,
    output sample_in,
    input  dac_cs_n,
    input  dac_sclk,
    input  dac_din
  );

  modport slave (
    input  sample_valid,
    input  sample_in,
    output dac_cs_n,
    output dac_sclk,
    output dac_din
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// Power-of-two sample buffer with registered level.
// A push into a full buffer is taken only when a pop frees a slot.
module audio_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 12
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_dac_tx.sv
// Buffered serializer for 16-bit DAC command frames.
// Frame period: LOAD + 32 SCLK half-periods + 2-half-period gap.
module audio_dac_tx
  import audio_dac_tx_pkg::*;
#(
  parameter int         CLK_DIV    = 2,
  parameter logic [3:0] CTRL_WORD  = CTRL_WORD_DEF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  audio_dac_tx_if.slave               io,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        ovf_sticky
);

  localparam logic [8:0] HALF_END = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_END  = 9'(2 * CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  dac_state_e            state;
  logic [8:0]            cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  cs_n_q;
  logic                  sclk_q;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  drop;
  logic [SAMPLE_W-1:0]   head;

  assign pop  = (state == LOAD);
  assign drop = io.sample_valid && full && !pop;

  assign io.dac_cs_n = cs_n_q;
  assign io.dac_sclk = sclk_q;
  assign io.dac_din  = shreg[FRAME_BITS-1];

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (io.sample_valid),
    .pop   (pop),
    .wdata (io.sample_in),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      overflow <= drop;
      if (drop) begin
        ovf_sticky <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shreg   <= {CTRL_WORD, head};
          cs_n_q  <= 1'b0;
          sclk_q  <= 1'b0;
          cnt     <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (cnt != HALF_END) begin
            cnt <= cnt + 9'd1;
          end else if (!sclk_q) begin
            cnt    <= '0;
            sclk_q <= 1'b1;
          end else begin
            // falling edge: advance data so din is stable at next rise
            cnt    <= '0;
            sclk_q <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              shreg  <= '0;
              cs_n_q <= 1'b1;
              state  <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        GAP: begin
          if (cnt != GAP_END) begin
            cnt <= cnt + 9'd1;
          end else begin
            cnt <= '0;
            if (!empty) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Randomized and directed bench for audio_dac_tx.
// Reference: frame schedule computed from arrival times.
module tb_audio_dac_tx;
  import audio_dac_tx_pkg::*;

  localparam int D     = 2;
  localparam int DEPTH = 4;
  localparam int FL    = 1 + 34 * D;
  localparam logic [3:0] CW = 4'b0011;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  audio_dac_tx_if bus();
  audio_dac_tx_if bus1();

  logic       busy, overflow, ovf_sticky;
  logic [2:0] fifo_level;
  logic       busy1, ovf1, st1;
  logic [2:0] lvl1;

  audio_dac_tx #(
    .CLK_DIV    (D),
    .CTRL_WORD  (CW),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .io         (bus),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky)
  );

  audio_dac_tx #(
    .CLK_DIV    (1),
    .CTRL_WORD  (CW),
    .FIFO_DEPTH (DEPTH)
  ) u_slow (
    .CLK        (CLK),
    .RST        (RST),
    .io         (bus1),
    .busy       (busy1),
    .fifo_level (lvl1),
    .overflow   (ovf1),
    .ovf_sticky (st1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // reference model state
  int          arr_q[$];
  int          ld_q[$];
  int          drop_q[$];
  logic [15:0] wd_q[$];
  logic [15:0] exp_q[$];
  int          last_ld = -100000;

  // captured frames
  logic [15:0] got_q[$];
  int          fall_q[$];
  int          len_q[$];
  int          nb_q[$];
  bit          in_frame = 0;
  logic [15:0] cap;
  int          cap_n;
  int          low_len;
  logic        prev_sclk = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic int occ(int c);
    int n;
    n = 0;
    foreach (arr_q[i]) if (arr_q[i] < c) n++;
    foreach (ld_q[i]) if (ld_q[i] < c) n--;
    return n;
  endfunction

  function automatic bit pop_at(int c);
    bit p;
    p = 0;
    foreach (ld_q[i]) if (ld_q[i] == c) p = 1;
    return p;
  endfunction

  task automatic model_push(int c, logic [11:0] s);
    int ld;
    if (occ(c) < DEPTH || pop_at(c)) begin
      ld = (c + 2 > last_ld + FL) ? c + 2 : last_ld + FL;
      arr_q.push_back(c);
      ld_q.push_back(ld);
      wd_q.push_back({CW, s});
      exp_q.push_back({CW, s});
      last_ld = ld;
    end else begin
      drop_q.push_back(c);
    end
  endtask

  task automatic model_reset();
    arr_q.delete();
    ld_q.delete();
    drop_q.delete();
    wd_q.delete();
    last_ld = -100000;
  endtask

  // {cs_n, sclk, din, busy, overflow, sticky, level}
  function automatic logic [8:0] exp_pins(int c);
    logic cs, sc, dn, bz, ov, st;
    int o, b;
    cs = 1; sc = 0; dn = 0; bz = 0; ov = 0; st = 0;
    foreach (ld_q[i]) begin
      if (c >= ld_q[i] && c <= ld_q[i] + 34 * D) begin
        bz = 1;
        o = c - ld_q[i] - 1;
        if (o >= 0 && o < 32 * D) begin
          cs = 0;
          b  = o / (2 * D);
          sc = (o % (2 * D)) >= D;
          dn = wd_q[i][15-b];
        end
      end
    end
    foreach (drop_q[i]) begin
      if (drop_q[i] == c - 1) ov = 1;
      if (drop_q[i] < c) st = 1;
    end
    return {cs, sc, dn, bz, ov, st, 3'(occ(c))};
  endfunction

  initial begin : mon
    forever begin
      @(negedge CLK);
      chk($sformatf("pins@%0d", cyc),
          {23'd0, bus.dac_cs_n, bus.dac_sclk, bus.dac_din,
           busy, overflow, ovf_sticky, fifo_level},
          {23'd0, exp_pins(cyc)});
      if (RST) begin
        in_frame  = 0;
        prev_sclk = 0;
      end else begin
        if (!bus.dac_cs_n) begin
          if (!in_frame) begin
            in_frame = 1;
            cap = '0;
            cap_n = 0;
            low_len = 0;
            fall_q.push_back(cyc);
          end
          low_len++;
          if (bus.dac_sclk && !prev_sclk) begin
            cap = {cap[14:0], bus.dac_din};
            cap_n++;
          end
        end else if (in_frame) begin
          in_frame = 0;
          got_q.push_back(cap);
          len_q.push_back(low_len);
          nb_q.push_back(cap_n);
        end
        prev_sclk = bus.dac_sclk;
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic drive(bit v, logic [11:0] s);
    tick();
    bus.sample_valid = v;
    bus.sample_in = s;
    if (v) model_push(cyc, s);
  endtask

  task automatic clear();
    got_q.delete();
    exp_q.delete();
    fall_q.delete();
    len_q.delete();
    nb_q.delete();
  endtask

  task automatic wait_frames(int n, int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      drive(0, 12'h0);
      k++;
    end
    chk("frame_wait", 32'(got_q.size() >= n), 1);
  endtask

  task automatic cmp_frames(string tag);
    chk({tag, "_n"}, got_q.size(), exp_q.size());
    foreach (got_q[i]) begin
      if (i < exp_q.size()) begin
        chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        chk($sformatf("%s_len%0d", tag, i), len_q[i], 32 * D);
        chk($sformatf("%s_bits%0d", tag, i), nb_q[i], 16);
      end
    end
  endtask

  initial begin : seq
    logic [11:0] s[7];
    int t, k;
    bus.sample_valid  = 0;
    bus.sample_in     = '0;
    bus1.sample_valid = 0;
    bus1.sample_in    = '0;

    repeat (3) tick();
    chk("rst_cs", bus.dac_cs_n, 1);
    chk("rst_sclk", bus.dac_sclk, 0);
    chk("rst_din", bus.dac_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sticky", ovf_sticky, 0);
    RST = 0;
    repeat (3) drive(0, 12'h0);

    // single frame
    clear();
    drive(1, 12'hA5C);
    wait_frames(1, 200);
    chk("single_word", got_q[0], 16'h3A5C);
    chk("single_len", len_q[0], 64);
    chk("gap_busy", busy, 1);
    repeat (5) drive(0, 12'h0);
    chk("single_done", busy, 0);

    // back to back
    clear();
    drive(1, 12'h001);
    drive(1, 12'hFFF);
    wait_frames(2, 400);
    chk("b2b_w0", got_q[0], 16'h3001);
    chk("b2b_w1", got_q[1], 16'h3FFF);
    chk("b2b_gap", fall_q[1] - fall_q[0], 69);
    repeat (8) drive(0, 12'h0);

    // overflow, then push during the LOAD pop
    clear();
    foreach (s[i]) s[i] = 12'($urandom_range(0, 4095));
    k = ld_q.size();
    for (int i = 0; i < 6; i++) drive(1, s[i]);
    drive(0, 12'h0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_sticky", ovf_sticky, 1);
    chk("ovf_lvl", fifo_level, 4);
    drive(0, 12'h0);
    chk("ovf_once", overflow, 0);
    t = ld_q[k+1];
    while (cyc < t - 1) drive(0, 12'h0);
    drive(1, s[6]);
    drive(0, 12'h0);
    chk("fwp_noovf", overflow, 0);
    chk("fwp_lvl", fifo_level, 4);
    wait_frames(6, 6 * FL + 100);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ovf_w%0d", i), got_q[i], {CW, s[i]});
    end
    chk("ovf_w5", got_q[5], {CW, s[6]});
    cmp_frames("ovf");
    repeat (8) drive(0, 12'h0);

    // random traffic
    clear();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) < 4,
            12'($urandom_range(0, 4095)));
    end
    k = 0;
    while (got_q.size() < exp_q.size() && k < 3000) begin
      drive(0, 12'h0);
      k++;
    end
    cmp_frames("rnd");
    repeat (8) drive(0, 12'h0);

    // reset mid-frame
    clear();
    drive(1, 12'($urandom_range(0, 4095)));
    drive(1, 12'($urandom_range(0, 4095)));
    k = 0;
    while (fall_q.size() == 0 && k < 20) begin
      drive(0, 12'h0);
      k++;
    end
    repeat (19) drive(0, 12'h0);
    tick();
    RST = 1;
    #1;
    chk("mid_cs", bus.dac_cs_n, 1);
    chk("mid_sclk", bus.dac_sclk, 0);
    chk("mid_lvl", fifo_level, 0);
    chk("mid_busy", busy, 0);
    model_reset();
    clear();
    repeat (3) tick();
    RST = 0;
    repeat (150) drive(0, 12'h0);
    chk("mid_noframe", fall_q.size(), 0);
    chk("mid_sticky", ovf_sticky, 0);
    drive(1, 12'h5A3);
    wait_frames(1, 200);
    chk("mid_word", got_q[0], 16'h35A3);
    repeat (8) drive(0, 12'h0);

    // CLK_DIV = 1 instance
    tick();
    bus1.sample_valid = 1;
    bus1.sample_in = 12'h800;
    tick();
    bus1.sample_valid = 0;
    begin
      int bz, rises, last_rise, badper;
      logic ps;
      logic [15:0] w;
      bz = 0; rises = 0; last_rise = -1; badper = 0;
      ps = 0; w = '0;
      repeat (80) begin
        @(negedge CLK);
        if (busy1) bz++;
        if (!bus1.dac_cs_n && bus1.dac_sclk && !ps) begin
          w = {w[14:0], bus1.dac_din};
          if (last_rise >= 0 && cyc - last_rise != 2) badper++;
          last_rise = cyc;
          rises++;
        end
        ps = bus1.dac_sclk;
      end
      chk("slow_word", w, 16'h3800);
      chk("slow_bits", rises, 16);
      chk("slow_per", badper, 0);
      chk("slow_busy", bz, 35);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
